// File: rtl/vx_tcu_fedp_seq.sv
// Operand-side issue sequencer for the TCU fused dot-product unit: streams K chunks
// into the FEDP, feeding each result back as the next accumulator, then returns it.
module vx_tcu_fedp_seq #(
  parameter int N       = 2,
  parameter int LATENCY = 4,
  parameter int KSTEP_W = 8,
  parameter int TAG_W   = 8,
  parameter int MASK_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_fmt_s,
  input  logic [3:0]           req_fmt_d,
  input  logic [KSTEP_W-1:0]   req_k_steps,
  input  logic [31:0]          req_c_init,
  input  logic [TAG_W-1:0]     req_tag,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [N*32-1:0]      op_a_row,
  input  logic [N*32-1:0]      op_b_col,
  output logic                 fedp_enable,
  output logic [MASK_W-1:0]    fedp_vld_mask,
  output logic [3:0]           fedp_fmt_s,
  output logic [3:0]           fedp_fmt_d,
  output logic [N*32-1:0]      fedp_a_row,
  output logic [N*32-1:0]      fedp_b_col,
  output logic [31:0]          fedp_c_val,
  input  logic [31:0]          fedp_d_val,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_d_val,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy
);

  // LATENCY+1 keeps the counter at least one bit wide when LATENCY==1
  localparam int WCNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RSP} state_t;

  state_t              state, state_n;
  logic [31:0]         acc_r;
  logic [KSTEP_W-1:0]  step_cnt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [3:0]          fmt_s_r, fmt_d_r;
  logic [TAG_W-1:0]    tag_r;
  logic [KSTEP_W-1:0]  k_r;
  logic                fire;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    op_ready  = 1'b0;
    rsp_valid = 1'b0;
    fire      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = (req_k_steps == '0) ? S_RSP : S_ISSUE;
      end
      S_ISSUE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          fire    = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_n = (step_cnt == k_r) ? S_RSP : S_ISSUE;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // handshakes are suppressed while reset is held, whatever the state register says
    if (reset) begin
      req_ready = 1'b0;
      op_ready  = 1'b0;
      rsp_valid = 1'b0;
      fire      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc_r    <= '0;
      step_cnt <= '0;
      wait_cnt <= '0;
      fmt_s_r  <= '0;
      fmt_d_r  <= '0;
      tag_r    <= '0;
      k_r      <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (req_valid) begin
          fmt_s_r  <= req_fmt_s;
          fmt_d_r  <= req_fmt_d;
          k_r      <= req_k_steps;
          tag_r    <= req_tag;
          acc_r    <= req_c_init;
          step_cnt <= '0;
        end
        S_ISSUE: if (fire) begin
          step_cnt <= step_cnt + 1'b1;
          wait_cnt <= WCNT_W'(LATENCY - 1);
        end
        // result of the chunk issued LATENCY cycles ago is on fedp_d_val now
        S_WAIT: begin
          if (wait_cnt == '0) acc_r <= fedp_d_val;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fedp_enable   = ~reset;
  assign fedp_vld_mask = {MASK_W{fire}};
  assign fedp_fmt_s    = fmt_s_r;
  assign fedp_fmt_d    = fmt_d_r;
  assign fedp_a_row    = op_a_row;
  assign fedp_b_col    = op_b_col;
  assign fedp_c_val    = acc_r;
  assign rsp_d_val     = acc_r;
  assign rsp_tag       = tag_r;
  assign busy          = ~reset && (state != S_IDLE);

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Bench for vx_tcu_fedp_seq: int32 FEDP stub, job-level reference model and a
// response scoreboard checked by an independent monitor.
module tb_vx_tcu_fedp_seq;
  localparam int N = 2, LAT = 4, KW = 8, TW = 8, MW = 8;
  localparam int TO = 3000;

  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready;
  logic [3:0] req_fmt_s = 0, req_fmt_d = 0;
  logic [KW-1:0] req_k_steps = 0;
  logic [31:0] req_c_init = 0;
  logic [TW-1:0] req_tag = 0;
  logic op_valid = 0, op_ready;
  logic [N*32-1:0] op_a_row = 0, op_b_col = 0;
  logic fedp_enable;
  logic [MW-1:0] fedp_vld_mask;
  logic [3:0] fedp_fmt_s, fedp_fmt_d;
  logic [N*32-1:0] fedp_a_row, fedp_b_col;
  logic [31:0] fedp_c_val, fedp_d_val;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_d_val;
  logic [TW-1:0] rsp_tag;
  logic busy;

  vx_tcu_fedp_seq #(.N(N), .LATENCY(LAT), .KSTEP_W(KW), .TAG_W(TW), .MASK_W(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
    .req_k_steps(req_k_steps), .req_c_init(req_c_init), .req_tag(req_tag),
    .op_valid(op_valid), .op_ready(op_ready), .op_a_row(op_a_row), .op_b_col(op_b_col),
    .fedp_enable(fedp_enable), .fedp_vld_mask(fedp_vld_mask), .fedp_fmt_s(fedp_fmt_s),
    .fedp_fmt_d(fedp_fmt_d), .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
    .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d_val(rsp_d_val), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FEDP stub: d = c + sum(a*b), LAT cycles later
  logic [31:0] dot;
  logic [31:0] pipe [LAT];
  always_comb begin
    dot = fedp_c_val;
    for (int i = 0; i < N; i++) dot = dot + fedp_a_row[i*32 +: 32] * fedp_b_col[i*32 +: 32];
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    else if (fedp_enable) begin
      pipe[0] <= dot;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fedp_d_val = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int mask_hi = 0, opr_hi = 0;
  always @(negedge clk) begin
    if (|fedp_vld_mask) mask_hi <= mask_hi + 1;
    if (op_ready) opr_hi <= opr_hi + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  typedef struct { logic [31:0] d; logic [TW-1:0] tag; } exp_t;
  exp_t sb_q [$];

  // monitor: every accepted response is matched against the oldest expected job
  initial forever begin
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_d_val", rsp_d_val, e.d);
        check("rsp_tag", rsp_tag, e.tag);
      end
    end
  end

  // mode 0: random data, 1: all-ones, 2: a=[1,2] b=[3,4]
  task automatic run_job(input int k, input int mode, input logic [31:0] c, input logic [TW-1:0] tg,
                         input int gap, input int rdly, input int exp_lat, input int abort_after);
    logic [31:0] ca [256][N];
    logic [31:0] cb [256][N];
    logic [31:0] expd;
    logic [3:0] fs, fd;
    exp_t e;
    int t, acc_cyc, last_fire, m0, o0;
    logic [31:0] d0;
    logic [TW-1:0] t0;
    expd = c;
    for (int s = 0; s < k; s++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          1: begin ca[s][i] = 1; cb[s][i] = 1; end
          2: begin ca[s][i] = i + 1; cb[s][i] = i + 3; end
          default: begin ca[s][i] = $urandom; cb[s][i] = $urandom; end
        endcase
        expd = expd + ca[s][i] * cb[s][i];
      end
    e.d = expd; e.tag = tg;
    sb_q.push_back(e);
    fs = 4'($urandom); fd = 4'($urandom);
    @(posedge clk); #1;
    req_valid = 1; req_k_steps = KW'(k); req_c_init = c; req_tag = tg;
    req_fmt_s = fs; req_fmt_d = fd;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < TO) begin @(negedge clk); t++; end
    if (t >= TO) begin check("req_timeout", 1, 0); return; end
    acc_cyc = cyc; m0 = mask_hi; o0 = opr_hi; last_fire = 0;
    @(posedge clk); #1;
    req_valid = 0;
    for (int s = 0; s < k; s++) begin
      if (gap > 0) begin
        op_valid = 0;
        repeat (gap) begin
          @(negedge clk);
          check("mask_gap", fedp_vld_mask, 0);
          @(posedge clk); #1;
        end
      end
      for (int i = 0; i < N; i++) begin
        op_a_row[i*32 +: 32] = ca[s][i];
        op_b_col[i*32 +: 32] = cb[s][i];
      end
      op_valid = 1;
      t = 0;
      @(negedge clk);
      while (!op_ready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) begin check("op_timeout", 1, 0); op_valid = 0; return; end
      check("mask_fire", fedp_vld_mask, {MW{1'b1}});
      check("fmt_s", fedp_fmt_s, fs);
      check("fmt_d", fedp_fmt_d, fd);
      if (s > 0 && gap == 0) check("issue_spacing", cyc - last_fire, LAT + 1);
      last_fire = cyc;
      @(posedge clk); #1;
      if (abort_after == s + 1) begin
        void'(sb_q.pop_back());
        op_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", fedp_enable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_busy", busy, 0);
        return;
      end
    end
    op_valid = 0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < TO) begin @(negedge clk); t++; end
    if (t >= TO) begin check("rsp_timeout", 1, 0); return; end
    if (exp_lat >= 0) check("job_latency", cyc - acc_cyc, exp_lat);
    if (k == 0) check("k0_no_op_ready", opr_hi - o0, 0);
    check("mask_count", mask_hi - m0, k);
    d0 = rsp_d_val; t0 = rsp_tag;
    repeat (rdly) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_d", rsp_d_val, d0);
      check("hold_tag", rsp_tag, t0);
      check("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("hs_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_op_ready", op_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_enable", fedp_enable, 0);
    check("reset_mask", fedp_vld_mask, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("idle_after_reset", req_ready, 1);
    check("enable_after_reset", fedp_enable, 1);

    run_job(1, 2, 32'd5, 8'h3A, 0, 0, 6, 0);                    // T1
    run_job(3, 1, 32'd0, 8'h11, 0, 0, 1 + 3*(LAT+1), 0);        // T2
    run_job(0, 0, 32'hDEADBEEF, 8'h22, 0, 0, 1, 0);             // T3
    run_job(2, 0, $urandom, 8'h33, 0, 5, -1, 0);                // T4
    run_job(3, 1, 32'd0, 8'h44, 3, 0, -1, 0);                   // T5
    run_job(4, 0, $urandom, 8'h55, 0, 0, -1, 2);                // T6 abort
    run_job(2, 0, $urandom, 8'h66, 0, 0, 1 + 2*(LAT+1), 0);     // job after abort
    run_job(255, 0, $urandom, 8'h77, 0, 0, 1 + 255*(LAT+1), 0); // max k, no wrap
    for (int j = 0; j < 20; j++)
      run_job($urandom_range(0, 6), 0, $urandom, TW'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 3), -1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
